i2s_clk_gen: RTL and testbench
==============================

I2S_CLK_GEN -- requirements
Module: i2s_clk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the bclk half-period divider.
REQ-002 SHALL have parameter BITS_PER_SLOT, default 16, bclk periods per slot; legal range 2 or more.
REQ-003 SHALL have parameter SLOTS, default 2, slots per frame; legal range 2 or more.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1, run request (level).
REQ-007 SHALL have port div_half, input, DIV_W, clk cycles per bclk half-period minus 1.
REQ-008 SHALL have port lj, input, 1, mode select: 0 = I2S (one-bit delay), 1 = left-justified.
REQ-009 SHALL have port bclk, output, 1, bit clock.
REQ-010 SHALL have port lrclk, output, 1, word select / frame sync.
REQ-011 SHALL have port bclk_fall, output, 1, one-clk pulse in the cycle bclk goes 1->0.
REQ-012 SHALL have port bclk_rise, output, 1, one-clk pulse in the cycle bclk goes 0->1.
REQ-013 SHALL have port frame_start, output, 1, one-clk pulse marking the start of slot 0 bit 0.
REQ-014 SHALL have port slot_idx, output, clog2(SLOTS), current slot.
REQ-015 SHALL have port bit_idx, output, clog2(BITS_PER_SLOT), current bit within the slot (0 = MSB).
REQ-016 SHALL have port busy, output, 1, high in states RUN and DRAIN.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DRAIN with the following transitions:
- IDLE->RUN when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->RUN when enable=1.
- DRAIN->IDLE at end of frame.
REQ-018 SHALL, in IDLE, hold bclk=0, lrclk=0, counters=0 and all pulses=0.
REQ-019 SHALL, on the IDLE->RUN clock, latch div_half and lj, clear the divider, and pulse frame_start; bclk starts low.
REQ-020 SHALL toggle bclk when the divider reaches the latched div_half, then reset the divider to 0: half-period = div_half+1 clks; div_half=0 gives bclk = clk/2.
REQ-021 SHALL assert bclk_rise and bclk_fall in the same cycle as the registered bclk edge they flag.
REQ-022 SHALL advance bit_idx on each bclk falling edge:
- wrap BITS_PER_SLOT-1 -> 0 and increment slot_idx;
- slot_idx wraps SLOTS-1 -> 0.
REQ-023 SHALL pulse frame_start on the falling edge where slot_idx wraps to 0, and re-latch div_half and lj there; mid-frame changes to div_half or lj SHALL have no effect.
REQ-024 SHALL, when SLOTS=2 and lj=1, drive lrclk=1 for slot 0 and 0 for slot 1, changing on the slot-boundary falling edge.
REQ-025 SHALL, when SLOTS=2 and lj=0, drive lrclk=0 for slot 0 and 1 for slot 1, changing on the falling edge that begins the last bit (BITS_PER_SLOT-1) of the preceding slot.
REQ-026 SHALL, when SLOTS>2 and lj=1, drive lrclk high for exactly one bclk period during slot 0 bit 0.
REQ-027 SHALL, when SLOTS>2 and lj=0, drive lrclk high for one bclk period during the last bit of slot SLOTS-1; the first frame after IDLE has no pre-pulse.
REQ-028 SHALL, in DRAIN, continue normally until the falling edge that would start a new frame, then enter IDLE on that edge with bclk=0 and lrclk=0 and without pulsing frame_start.
REQ-029 SHALL, if enable returns to 1 during DRAIN, go to RUN with no bclk gap and no counter disturbance.
REQ-030 SHALL keep every bclk high and low phase exactly div_half+1 clks with no glitch or runt phase, including at state transitions.

Reset
REQ-031 SHALL, when rst_n=0, asynchronously force state IDLE, bclk=0, lrclk=0, bclk_rise=bclk_fall=frame_start=0, slot_idx=0, bit_idx=0, busy=0, and clear the divider and latched configuration.
REQ-032 SHALL, after rst_n deasserts while enable=1, enter RUN on the first clk edge.
REQ-033 SHALL, when rst_n asserts mid-frame, abort the frame immediately with no drain.

Verification
REQ-034 SHALL verify default config with div_half=15, lj=1 -> bclk period 32 clks, lrclk toggles every 512 clks, frame_start every 1024 clks.
REQ-035 SHALL verify div_half=0, lj=0, SLOTS=2 -> bclk = clk/2; lrclk rises at the falling edge starting slot0 bit15 and falls at the one starting slot1 bit15.
REQ-036 SHALL verify SLOTS=4, BITS_PER_SLOT=8, lj=1, div_half=3 -> lrclk high 8 clks every 256 clks, aligned with frame_start.
REQ-037 SHALL verify enable dropped at slot0 bit3 -> frame completes, IDLE at frame end, bclk=0, busy=0, no extra frame_start.
REQ-038 SHALL verify div_half changed 15->7 mid-frame -> old period persists until the next frame_start, then 16-clk period.
REQ-039 SHALL verify rst_n pulsed low mid-frame -> all outputs 0 immediately without waiting for clk; restart begins with frame_start and bit_idx=0.

Source files
------------

// File: rtl/i2s_clk_gen.sv
// I2S / left-justified bit-clock and frame-sync generator.
// A programmable divider produces bclk; slot and bit counters advance on bclk falling edges.
module i2s_clk_gen #(
   parameter int DIV_W         = 8,
   parameter int BITS_PER_SLOT = 16,
   parameter int SLOTS         = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   input  logic [DIV_W-1:0]                 div_half,
   input  logic                             lj,
   output logic                             bclk,
   output logic                             lrclk,
   output logic                             bclk_fall,
   output logic                             bclk_rise,
   output logic                             frame_start,
   output logic [$clog2(SLOTS)-1:0]         slot_idx,
   output logic [$clog2(BITS_PER_SLOT)-1:0] bit_idx,
   output logic                             busy
);

   localparam int SLOT_W = $clog2(SLOTS);
   localparam int BIT_W  = $clog2(BITS_PER_SLOT);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_SLOT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state, state_nxt;
   logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
   logic [DIV_W-1:0]   div_lat, div_lat_nxt;
   logic               lj_lat, lj_lat_nxt;
   logic               bclk_nxt, lrclk_nxt, rise_nxt, fall_nxt, fs_nxt;
   logic [SLOT_W-1:0]  slot_nxt;
   logic [BIT_W-1:0]   bit_nxt;
   logic               toggle, frame_wrap;

   // Frame-sync level for the bit that starts at (s, b).
   function automatic logic lr_level(input logic [SLOT_W-1:0] s,
                                     input logic [BIT_W-1:0]  b,
                                     input logic              mode_lj);
      logic last_bit;
      logic first_bit;
      last_bit  = (b == BIT_LAST);
      first_bit = (b == '0);
      if (SLOTS == 2) begin
         if (mode_lj) return (s == '0);
         else         return (s == '0) ? last_bit : !last_bit;
      end else begin
         if (mode_lj) return (s == '0) && first_bit;
         else         return (s == SLOT_LAST) && last_bit;
      end
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
      state_nxt   = state;
      div_cnt_nxt = div_cnt;
      div_lat_nxt = div_lat;
      lj_lat_nxt  = lj_lat;
      bclk_nxt    = bclk;
      lrclk_nxt   = lrclk;
      rise_nxt    = 1'b0;
      fall_nxt    = 1'b0;
      fs_nxt      = 1'b0;
      slot_nxt    = slot_idx;
      bit_nxt     = bit_idx;
      toggle      = (div_cnt == div_lat);
      frame_wrap  = (bit_idx == BIT_LAST) && (slot_idx == SLOT_LAST);

      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt   = RUN;
               div_lat_nxt = div_half;
               lj_lat_nxt  = lj;
               div_cnt_nxt = '0;
               fs_nxt      = 1'b1;
               bclk_nxt    = 1'b0;
               slot_nxt    = '0;
               bit_nxt     = '0;
               lrclk_nxt   = lr_level('0, '0, lj);
            end
         end
         RUN, DRAIN: begin
            if (state == RUN && !enable)  state_nxt = DRAIN;
            if (state == DRAIN && enable) state_nxt = RUN;

            if (!toggle) begin
               div_cnt_nxt = div_cnt + DIV_W'(1);
            end else begin
               div_cnt_nxt = '0;
               bclk_nxt    = !bclk;
               rise_nxt    = !bclk;
               fall_nxt    = bclk;
               if (bclk) begin
                  if (frame_wrap) begin
                     slot_nxt = '0;
                     bit_nxt  = '0;
                     // A drain ends on the edge that would open the next frame.
                     if (state == DRAIN && !enable) begin
                        state_nxt = IDLE;
                        lrclk_nxt = 1'b0;
                     end else begin
                        fs_nxt      = 1'b1;
                        div_lat_nxt = div_half;
                        lj_lat_nxt  = lj;
                        lrclk_nxt   = lr_level('0, '0, lj);
                     end
                  end else begin
                     if (bit_idx == BIT_LAST) begin
                        bit_nxt  = '0;
                        slot_nxt = slot_idx + SLOT_W'(1);
                     end else begin
                        bit_nxt  = bit_idx + BIT_W'(1);
                     end
                     lrclk_nxt = lr_level(slot_nxt, bit_nxt, lj_lat);
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         div_cnt     <= '0;
         div_lat     <= '0;
         lj_lat      <= 1'b0;
         bclk        <= 1'b0;
         lrclk       <= 1'b0;
         bclk_rise   <= 1'b0;
         bclk_fall   <= 1'b0;
         frame_start <= 1'b0;
         slot_idx    <= '0;
         bit_idx     <= '0;
      end else begin
         state       <= state_nxt;
         div_cnt     <= div_cnt_nxt;
         div_lat     <= div_lat_nxt;
         lj_lat      <= lj_lat_nxt;
         bclk        <= bclk_nxt;
         lrclk       <= lrclk_nxt;
         bclk_rise   <= rise_nxt;
         bclk_fall   <= fall_nxt;
         frame_start <= fs_nxt;
         slot_idx    <= slot_nxt;
         bit_idx     <= bit_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Self-checking bench for i2s_clk_gen: a default 2x16 instance and a 4x8 instance.
// Expected cycle distances are queued when stimulus is applied and popped when the event is seen.
module tb_i2s_clk_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       enable = 1'b0;
   logic       lj = 1'b1;
   logic [7:0] div_half = 8'd15;
   logic       bclk, lrclk, bclk_fall, bclk_rise, frame_start, busy;
   logic [0:0] slot_idx;
   logic [3:0] bit_idx;

   logic       enable4 = 1'b0;
   logic       lj4 = 1'b1;
   logic [7:0] div_half4 = 8'd3;
   logic       bclk4, lrclk4, bclk_fall4, bclk_rise4, frame_start4, busy4;
   logic [1:0] slot_idx4;
   logic [2:0] bit_idx4;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int exp_q[$];

   i2s_clk_gen dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .div_half(div_half), .lj(lj),
      .bclk(bclk), .lrclk(lrclk), .bclk_fall(bclk_fall), .bclk_rise(bclk_rise),
      .frame_start(frame_start), .slot_idx(slot_idx), .bit_idx(bit_idx), .busy(busy)
   );

   i2s_clk_gen #(.DIV_W(8), .BITS_PER_SLOT(8), .SLOTS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable4), .div_half(div_half4), .lj(lj4),
      .bclk(bclk4), .lrclk(lrclk4), .bclk_fall(bclk_fall4), .bclk_rise(bclk_rise4),
      .frame_start(frame_start4), .slot_idx(slot_idx4), .bit_idx(bit_idx4), .busy(busy4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit sig(input int sel);
      case (sel)
         0:  return frame_start;
         1:  return bclk_rise;
         2:  return bclk_fall;
         3:  return lrclk;
         4:  return !lrclk;
         5:  return !busy;
         10: return frame_start4;
         13: return lrclk4;
         14: return !lrclk4;
         default: return 1'b0;
      endcase
   endfunction

   // Waits for a 0->1 transition of the selected condition, sampled on falling clk edges.
   task automatic wait_evt(input int sel, input int budget, input string name, output int t);
      bit prev, cur;
      prev = sig(sel);
      t = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cur = sig(sel);
         if (cur && !prev) begin
            t = cyc;
            break;
         end
         prev = cur;
      end
      checks++;
      if (t < 0) begin
         failures++;
         $display("FAIL %s: event not seen within %0d cycles, required one", name, budget);
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy, slot_idx, bit_idx} !== '0) begin
         failures++;
         $display("FAIL reset_async: outputs=%b required all 0",
                  {bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy, slot_idx, bit_idx});
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({bclk4, lrclk4, bclk_rise4, bclk_fall4, frame_start4, busy4, slot_idx4, bit_idx4} !== '0) begin
         failures++;
         $display("FAIL reset_dut4: outputs=%b required all 0",
                  {bclk4, lrclk4, bclk_rise4, bclk_fall4, frame_start4, busy4, slot_idx4, bit_idx4});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, bclk, lrclk, frame_start} !== 4'b0000) begin
         failures++;
         $display("FAIL idle_hold: busy/bclk/lrclk/fs=%b required 0000", {busy, bclk, lrclk, frame_start});
      end
      enable = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, frame_start, bclk, lrclk, bit_idx} !== {1'b1, 1'b1, 1'b0, 1'b1, 4'd0}) begin
         failures++;
         $display("FAIL start: busy/fs/bclk/lrclk/bit=%b required 1101_0000",
                  {busy, frame_start, bclk, lrclk, bit_idx});
      end
   endtask

   task automatic test_default();
      int t0, t, ta, tb, tc, e;
      t0 = cyc;
      exp_q.push_back(512);
      exp_q.push_back(1024);
      exp_q.push_back(32);
      exp_q.push_back(16);
      wait_evt(4, 2000, "lj_lrclk_fall", t);
      e = exp_q.pop_front();
      checks++;
      if (t - t0 !== e) begin
         failures++;
         $display("FAIL lj_lrclk_fall: offset=%0d required %0d", t - t0, e);
      end
      wait_evt(0, 2000, "lj_frame", t);
      e = exp_q.pop_front();
      checks++;
      if (t - t0 !== e) begin
         failures++;
         $display("FAIL lj_frame_period: got %0d required %0d", t - t0, e);
      end
      checks++;
      if ({lrclk, slot_idx, bit_idx} !== {1'b1, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL lj_frame_state: lrclk/slot/bit=%b required 1_0_0000", {lrclk, slot_idx, bit_idx});
      end
      wait_evt(1, 100, "lj_rise_a", ta);
      wait_evt(2, 100, "lj_fall", tb);
      wait_evt(1, 100, "lj_rise_b", tc);
      e = exp_q.pop_front();
      checks++;
      if (tc - ta !== e) begin
         failures++;
         $display("FAIL lj_bclk_period: got %0d required %0d", tc - ta, e);
      end
      e = exp_q.pop_front();
      checks++;
      if (tb - ta !== e) begin
         failures++;
         $display("FAIL lj_bclk_high: got %0d required %0d", tb - ta, e);
      end
   endtask

   task automatic test_i2s();
      int t0, t, ta, tb, e;
      div_half = 8'd0;
      lj = 1'b0;
      wait_evt(0, 2000, "i2s_frame_a", t0);
      exp_q.push_back(30);
      exp_q.push_back(62);
      exp_q.push_back(64);
      exp_q.push_back(2);
      checks++;
      if (lrclk !== 1'b0) begin
         failures++;
         $display("FAIL i2s_lr_start: lrclk=%b required 0", lrclk);
      end
      wait_evt(3, 200, "i2s_lr_rise", t);
      e = exp_q.pop_front();
      checks++;
      if (t - t0 !== e || slot_idx !== 1'b0 || bit_idx !== 4'd15) begin
         failures++;
         $display("FAIL i2s_lr_rise: offset=%0d slot=%0d bit=%0d required %0d/0/15", t - t0, slot_idx, bit_idx, e);
      end
      wait_evt(4, 200, "i2s_lr_fall", t);
      e = exp_q.pop_front();
      checks++;
      if (t - t0 !== e || slot_idx !== 1'b1 || bit_idx !== 4'd15) begin
         failures++;
         $display("FAIL i2s_lr_fall: offset=%0d slot=%0d bit=%0d required %0d/1/15", t - t0, slot_idx, bit_idx, e);
      end
      wait_evt(0, 200, "i2s_frame_b", t);
      e = exp_q.pop_front();
      checks++;
      if (t - t0 !== e) begin
         failures++;
         $display("FAIL i2s_frame_period: got %0d required %0d", t - t0, e);
      end
      wait_evt(1, 20, "i2s_rise_a", ta);
      wait_evt(1, 20, "i2s_rise_b", tb);
      e = exp_q.pop_front();
      checks++;
      if (tb - ta !== e) begin
         failures++;
         $display("FAIL i2s_bclk_period: got %0d required %0d", tb - ta, e);
      end
   endtask

   task automatic test_drain();
      int t0, t, e, n_fs;
      wait_evt(0, 200, "drain_frame", t0);
      for (int i = 0; i < 3; i++) wait_evt(2, 20, "drain_bit", t);
      checks++;
      if (bit_idx !== 4'd3 || slot_idx !== 1'b0) begin
         failures++;
         $display("FAIL drain_point: slot=%0d bit=%0d required 0/3", slot_idx, bit_idx);
      end
      enable = 1'b0;
      exp_q.push_back(64);
      wait_evt(5, 200, "drain_idle", t);
      e = exp_q.pop_front();
      checks++;
      if (t - t0 !== e) begin
         failures++;
         $display("FAIL drain_end: offset=%0d required %0d", t - t0, e);
      end
      checks++;
      if ({bclk, lrclk, frame_start, slot_idx, bit_idx} !== '0) begin
         failures++;
         $display("FAIL drain_idle_state: bclk/lr/fs/slot/bit=%b required 0", {bclk, lrclk, frame_start, slot_idx, bit_idx});
      end
      n_fs = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (frame_start) n_fs++;
      end
      checks++;
      if (n_fs !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL drain_quiet: frame_starts=%0d busy=%b required 0/0", n_fs, busy);
      end
   endtask

   task automatic test_back_to_back();
      int t0, t, ta, tb, e;
      enable = 1'b1;
      wait_evt(0, 5, "b2b_start", t0);
      exp_q.push_back(64);
      exp_q.push_back(2);
      repeat (10) @(negedge clk);
      enable = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_drain_busy: busy=%b required 1", busy);
      end
      enable = 1'b1;
      wait_evt(0, 200, "b2b_frame", t);
      e = exp_q.pop_front();
      checks++;
      if (t - t0 !== e) begin
         failures++;
         $display("FAIL b2b_frame_period: got %0d required %0d", t - t0, e);
      end
      wait_evt(1, 20, "b2b_rise_a", ta);
      wait_evt(1, 20, "b2b_rise_b", tb);
      e = exp_q.pop_front();
      checks++;
      if (tb - ta !== e) begin
         failures++;
         $display("FAIL b2b_bclk_period: got %0d required %0d", tb - ta, e);
      end
   endtask

   task automatic test_div_change();
      int t0, t1, ta, tb, e;
      div_half = 8'd15;
      lj = 1'b1;
      wait_evt(0, 200, "div_frame_a", t0);
      div_half = 8'd7;
      exp_q.push_back(32);
      exp_q.push_back(1024);
      exp_q.push_back(8);
      exp_q.push_back(16);
      wait_evt(1, 100, "div_rise_a", ta);
      wait_evt(1, 100, "div_rise_b", tb);
      e = exp_q.pop_front();
      checks++;
      if (tb - ta !== e) begin
         failures++;
         $display("FAIL div_old_period: got %0d required %0d", tb - ta, e);
      end
      wait_evt(0, 2000, "div_frame_b", t1);
      e = exp_q.pop_front();
      checks++;
      if (t1 - t0 !== e) begin
         failures++;
         $display("FAIL div_old_frame: got %0d required %0d", t1 - t0, e);
      end
      wait_evt(1, 100, "div_rise_c", ta);
      e = exp_q.pop_front();
      checks++;
      if (ta - t1 !== e) begin
         failures++;
         $display("FAIL div_new_low: got %0d required %0d", ta - t1, e);
      end
      wait_evt(1, 100, "div_rise_d", tb);
      e = exp_q.pop_front();
      checks++;
      if (tb - ta !== e) begin
         failures++;
         $display("FAIL div_new_period: got %0d required %0d", tb - ta, e);
      end
   endtask

   task automatic test_slots4();
      int t0, t, tr, tf, e;
      div_half4 = 8'd3;
      lj4 = 1'b1;
      enable4 = 1'b1;
      wait_evt(10, 5, "s4_start", t0);
      exp_q.push_back(8);
      exp_q.push_back(256);
      exp_q.push_back(256);
      exp_q.push_back(248);
      exp_q.push_back(256);
      checks++;
      if (lrclk4 !== 1'b1) begin
         failures++;
         $display("FAIL s4_lr_align: lrclk=%b required 1", lrclk4);
      end
      wait_evt(14, 100, "s4_lr_fall", t);
      e = exp_q.pop_front();
      checks++;
      if (t - t0 !== e) begin
         failures++;
         $display("FAIL s4_lr_width: got %0d required %0d", t - t0, e);
      end
      wait_evt(13, 400, "s4_lr_rise", tr);
      e = exp_q.pop_front();
      checks++;
      if (tr - t0 !== e || frame_start4 !== 1'b1) begin
         failures++;
         $display("FAIL s4_lr_period: got %0d fs=%b required %0d/1", tr - t0, frame_start4, e);
      end
      lj4 = 1'b0;
      wait_evt(10, 400, "s4_frame", tf);
      e = exp_q.pop_front();
      checks++;
      if (tf - tr !== e || lrclk4 !== 1'b0) begin
         failures++;
         $display("FAIL s4_i2s_frame: got %0d lrclk=%b required %0d/0", tf - tr, lrclk4, e);
      end
      wait_evt(13, 400, "s4_pre_rise", t);
      e = exp_q.pop_front();
      checks++;
      if (t - tf !== e || slot_idx4 !== 2'd3 || bit_idx4 !== 3'd7) begin
         failures++;
         $display("FAIL s4_pre_pulse: offset=%0d slot=%0d bit=%0d required %0d/3/7", t - tf, slot_idx4, bit_idx4, e);
      end
      wait_evt(14, 100, "s4_pre_fall", t);
      e = exp_q.pop_front();
      checks++;
      if (t - tf !== e || frame_start4 !== 1'b1) begin
         failures++;
         $display("FAIL s4_pre_end: offset=%0d fs=%b required %0d/1", t - tf, frame_start4, e);
      end
      enable4 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int t, ta, e;
      wait_evt(1, 100, "rst_mid_rise", t);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy, slot_idx, bit_idx} !== '0) begin
         failures++;
         $display("FAIL rst_mid_async: outputs=%b required all 0",
                  {bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy, slot_idx, bit_idx});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(8);
      @(negedge clk);
      ta = cyc;
      checks++;
      if ({frame_start, busy, slot_idx, bit_idx} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL rst_restart: fs/busy/slot/bit=%b required 11_0_0000", {frame_start, busy, slot_idx, bit_idx});
      end
      wait_evt(1, 100, "rst_restart_rise", t);
      e = exp_q.pop_front();
      checks++;
      if (t - ta !== e) begin
         failures++;
         $display("FAIL rst_restart_low: got %0d required %0d", t - ta, e);
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_i2s();
      test_drain();
      test_back_to_back();
      test_div_change();
      test_slots4();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
